// File: rtl/clk_en_gen.sv
// Lock-qualified reset sequencer plus NUM_CH programmable clock-enable dividers on the PLL clock.
// Optional CLK_EN_GEN_LOSS_COUNT_EN adds a saturating lock-loss counter output (loss_count).
module clk_en_gen #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned LOCK_STABLE = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pll_locked,
    input  logic [NUM_CH*DIV_W-1:0]   div,
    input  logic                      clear,
    output logic                      rst_out,
    output logic                      ready,
    output logic [NUM_CH-1:0]         ce,
    output logic                      lock_lost
`ifdef CLK_EN_GEN_LOSS_COUNT_EN
    ,
    output logic [7:0]                loss_count
`endif
);

    localparam int unsigned CNT_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    state_t                         state;
    logic                           sync0;
    logic                           lk;
    logic [CNT_W-1:0]               stable_cnt;
    logic [NUM_CH-1:0][DIV_W-1:0]   cnt;
    logic                           lock_drop;

    assign lock_drop = (state == RUN) && !lk;
    assign rst_out   = (state != RUN);
    assign ready     = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync0 <= pll_locked;
            lk    <= sync0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
            lock_lost  <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lk) begin
                        state      <= STABLE;
                        stable_cnt <= '0;
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state      <= WAIT_LOCK;
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state <= RUN;
                    end else begin
                        stable_cnt <= stable_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase

            // a loss in the same cycle as clear must still be recorded
            if (lock_drop) begin
                lock_lost <= 1'b1;
            end else if (clear) begin
                lock_lost <= 1'b0;
            end
        end
    end

    // divisors are only sampled on reload, so a div change never truncates a running period
    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (reset || (state != RUN) || (cnt[n] == '0)) begin
                cnt[n] <= div[n*DIV_W +: DIV_W];
            end else begin
                cnt[n] <= cnt[n] - DIV_W'(1);
            end
        end
    end

    always_comb begin
        ce = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            ce[n] = (state == RUN) && (cnt[n] == '0);
        end
    end

`ifdef CLK_EN_GEN_LOSS_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            loss_count <= '0;
        end else if (lock_drop) begin
            if (clear) begin
                loss_count <= 8'd1;
            end else if (loss_count != 8'hff) begin
                loss_count <= loss_count + 8'd1;
            end
        end else if (clear) begin
            loss_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Randomised self-checking bench for clk_en_gen against a streak/schedule reference model.
// Define CLK_EN_GEN_LOSS_COUNT_EN for both files to exercise loss_count.
module tb_clk_en_gen;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned LS     = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    pll_locked;
    logic [NUM_CH*DIV_W-1:0] div;
    logic                    clear;
    logic                    rst_out;
    logic                    ready;
    logic [NUM_CH-1:0]       ce;
    logic                    lock_lost;
`ifdef CLK_EN_GEN_LOSS_COUNT_EN
    logic [7:0]              loss_count;
`endif

    always #5 clk = ~clk;

    clk_en_gen #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .LOCK_STABLE(LS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_locked(pll_locked),
        .div       (div),
        .clear     (clear),
        .rst_out   (rst_out),
        .ready     (ready),
        .ce        (ce),
        .lock_lost (lock_lost)
`ifdef CLK_EN_GEN_LOSS_COUNT_EN
        ,
        .loss_count(loss_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: lk is pll_locked two edges late; RUN holds whenever lk has been
    // seen high on at least LS+1 consecutive edges; each channel fires on a schedule.
    bit m_d1, m_d2;
    int streak;
    bit m_run;
    bit m_lost;
    int m_loss;
    int run_idx;
    int next_fire [NUM_CH];
    int edge_no;

    task automatic model_update();
        bit was_run;
        bit lk;
        int d;
        edge_no++;
        if (reset) begin
            m_d1 = 0; m_d2 = 0; streak = 0; m_run = 0; m_lost = 0; m_loss = 0; run_idx = 0;
            for (int n = 0; n < NUM_CH; n++) next_fire[n] = int'(div[n*DIV_W +: DIV_W]);
        end else begin
            was_run = m_run;
            lk = m_d2;
            m_d2 = m_d1;
            m_d1 = pll_locked;
            if (lk) begin
                if (streak < 1000000) streak++;
            end else begin
                streak = 0;
            end
            m_run = (streak >= LS + 1);
            if (was_run && !lk) begin
                m_lost = 1;
                m_loss = clear ? 1 : ((m_loss < 255) ? m_loss + 1 : 255);
            end else if (clear) begin
                m_lost = 0;
                m_loss = 0;
            end
            for (int n = 0; n < NUM_CH; n++) begin
                d = int'(div[n*DIV_W +: DIV_W]);
                if (!was_run) next_fire[n] = d;
                else if (run_idx == next_fire[n]) next_fire[n] = run_idx + d + 1;
            end
            run_idx = was_run ? run_idx + 1 : 0;
        end
    endtask

    task automatic step();
        logic [NUM_CH-1:0] exp_ce;
        @(posedge clk);
        model_update();
        #1;
        for (int n = 0; n < NUM_CH; n++) exp_ce[n] = m_run && (run_idx == next_fire[n]);
        check("rst_out", rst_out, !m_run);
        check("ready", ready, m_run);
        check("ce", ce, exp_ce);
        check("lock_lost", lock_lost, m_lost);
`ifdef CLK_EN_GEN_LOSS_COUNT_EN
        check("loss_count", loss_count, m_loss);
`endif
    endtask

    // steps until rst_out falls; -1 if it never does within the budget
    task automatic wait_release(output int n_steps);
        n_steps = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (!rst_out) begin
                n_steps = k;
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int ns;
        int first_ce2;
        int ch;
        reset = 1; pll_locked = 0; clear = 0;
        div = '0;
        div[0*DIV_W +: DIV_W] = 16'd0;
        div[1*DIV_W +: DIV_W] = 16'd3;
        div[2*DIV_W +: DIV_W] = 16'd9;
        div[3*DIV_W +: DIV_W] = 16'd5;
        repeat (3) step();
        check("reset_rst_out", rst_out, 1);
        check("reset_ce", ce, 0);

        // lock rises at edge 10 after reset release: release expected at edge 28
        reset = 0;
        edge_no = 0;
        repeat (9) step();
        pll_locked = 1;
        wait_release(ns);
        check("release_steps", ns, 19);
        check("release_edge", edge_no, 28);
        check("ready_at_release", ready, 1);

        first_ce2 = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (ce[2] && first_ce2 < 0) first_ce2 = k;
        end
        check("first_ce2", first_ce2, 9);

        // divisor change mid-period
        repeat (2) step();
        div[1*DIV_W +: DIV_W] = 16'd7;
        repeat (40) step();

        // glitch during STABLE restarts the count
        pll_locked = 0;
        repeat (6) step();
        pll_locked = 1;
        repeat (12) step();
        pll_locked = 0;
        step();
        pll_locked = 1;
        wait_release(ns);
        check("glitch_release_steps", ns, 19);
        repeat (10) step();

        // lock loss, clear, and clear coincident with a loss
        pll_locked = 0;
        step();
        step();
        check("loss_not_yet", rst_out, 0);
        step();
        check("loss_rst_out", rst_out, 1);
        check("loss_flag", lock_lost, 1);
        clear = 1;
        step();
        clear = 0;
        check("cleared_flag", lock_lost, 0);
        pll_locked = 1;
        wait_release(ns);
        check("relock_steps", ns, 19);
        repeat (5) step();
        pll_locked = 0;
        step();
        step();
        clear = 1;
        step();
        clear = 0;
        check("loss_beats_clear", lock_lost, 1);

        // reset mid-RUN
        pll_locked = 1;
        wait_release(ns);
        repeat (3) step();
        reset = 1;
        step();
        reset = 0;
        check("mid_run_reset", rst_out, 1);
        check("mid_run_reset_flag", lock_lost, 0);

        // randomised phase
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                reset = 1;
                step();
                reset = 0;
            end
            pll_locked = 1;
            repeat ($urandom_range(3, 50)) begin
                clear = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    ch = $urandom_range(0, NUM_CH - 1);
                    div[ch*DIV_W +: DIV_W] = 16'($urandom_range(0, 12));
                end
                step();
            end
            clear = 0;
            pll_locked = 0;
            repeat ($urandom_range(1, 5)) step();
        end

`ifdef CLK_EN_GEN_LOSS_COUNT_EN
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1;
            wait_release(ns);
            step();
            pll_locked = 0;
            repeat (3) step();
        end
        check("loss_count_sat", loss_count, 255);
        clear = 1;
        step();
        clear = 0;
        check("loss_count_clear", loss_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Lock-qualified reset sequencer and multi-channel clock-enable generator running on the PLL output clock domain. It watches the PLL lock indication, holds the design in reset until lock has been continuously stable for a parametrised time, then releases reset and emits NUM_CH independent single-cycle clock-enable strobes at runtime-programmable rates. A lock loss re-asserts reset immediately and records a sticky fault flag. It sits directly downstream of the board PLL wrapper and feeds reset and enables to the quadrature and I/O logic.

## Interface
- NUM_CH, 4: number of clock-enable channels (1..8).
- DIV_W, 16: width of each channel divisor.
- LOCK_STABLE, 1024: cycles of continuous synchronised lock required before reset release (>= 1).

- clk  in  1  PLL global output clock; sole clock.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- pll_locked  in  1  raw PLL LOCK; asynchronous to clk, synchronised internally.
- div  in  NUM_CH*DIV_W  channel divisors; channel n uses div[n*DIV_W +: DIV_W].
- clear  in  1  single-cycle pulse; clears lock_lost.
- rst_out  out  1  reset to downstream logic, active-high.
- ready  out  1  high exactly when state is RUN.
- ce  out  NUM_CH  per-channel single-cycle enable strobes.
- lock_lost  out  1  sticky: lock dropped while in RUN.

## Operation
- pll_locked passes through a 2-flop synchroniser; lk denotes the second flop output.
- FSM states: WAIT_LOCK, STABLE, RUN. reset forces WAIT_LOCK, stable counter 0, synchroniser flops 0, lock_lost 0.
- WAIT_LOCK: lk=1 -> STABLE with counter 0.
- STABLE: counter increments each cycle lk=1; lk=0 -> WAIT_LOCK, counter 0; counter == LOCK_STABLE-1 with lk=1 -> RUN.
- RUN: lk=0 -> WAIT_LOCK and lock_lost set the same edge.
- rst_out = (state != RUN); ready = (state == RUN); both derived from the state register only.
- Divider channel n: down-counter cnt[n], DIV_W bits. When not RUN, cnt[n] loads div[n] every cycle and ce[n]=0. In RUN: ce[n] = (cnt[n]==0); if cnt[n]==0 reload div[n], else decrement.
- Period of ce[n] is div[n]+1 cycles; div[n]=0 gives ce[n] high every RUN cycle. div changes take effect only at the next reload (no mid-period glitch).
- lock_lost: set has priority over clear when both occur in one cycle.
- Reset outputs: rst_out=1, ready=0, ce=0, lock_lost=0.

## Timing
- pll_locked edge sampled at edge t -> lk high at t+2 -> STABLE from t+2.
- rst_out falls LOCK_STABLE cycles after entering STABLE (t+2+LOCK_STABLE), provided lk stays high.
- First ce[n] in the RUN cycle with index div[n] (0-based from first RUN cycle).
- Lock loss: rst_out rises and ce drops to 0 two cycles after pll_locked falling edge is sampled.
- Glitch of lk low for one cycle in STABLE restarts the full LOCK_STABLE count.
- reset asserted mid-RUN: next edge rst_out=1, ce=0, lock_lost=0; no lock_lost set by reset.

## Configuration
- CLK_EN_GEN_LOSS_COUNT_EN defined: adds output loss_count [7:0], incremented on each RUN->WAIT_LOCK transition caused by lk=0, saturating at 255, cleared by reset and by clear (a loss in the same cycle as clear yields 1).
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- LOCK_STABLE=16, pll_locked rises at edge 10 -> rst_out falls at edge 28, ready rises same edge.
- div ch0=0, ch1=3, ch2=9 after release -> ce0 every cycle, ce1 every 4 cycles first at RUN cycle 3, ce2 every 10 cycles first at RUN cycle 9.
- In STABLE at count 10, pll_locked low 1 cycle -> return to WAIT_LOCK; release occurs 16 cycles after lk re-rises.
- In RUN drop pll_locked -> 2 cycles later rst_out=1, ce=0, lock_lost=1; clear pulse -> lock_lost=0; clear coincident with new loss -> lock_lost=1.
- Change ch1 div 3->7 mid-period -> current period completes at 4 cycles, next periods 8 cycles.
- With CLK_EN_GEN_LOSS_COUNT_EN: 300 lock-loss/relock cycles -> loss_count=255; clear -> 0.
